// File: rtl/sw_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding and
// the helper that tells whether a state keeps the clock running.
package sw_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_t;

   function automatic logic is_running(input state_t s);
      return (s == ST_RUN) || (s == ST_LAP);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchronizer, stability-window debouncer and a
// registered one-cycle pulse on each debounced rising edge.
module btn_debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_press
);

   localparam int                CW      = $clog2(DB_CYCLES);
   localparam logic [CW-1:0]     CNT_MAX = CW'(DB_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic [CW-1:0] r_cnt;
   logic          r_press;

   // The counter runs only while the synchronized input disagrees with the
   // debounced level; any agreement restarts the window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
            r_press <= r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/sw_ctrl.sv
// Stopwatch control: debounced buttons drive an IDLE/RUN/PAUSE/LAP FSM and a
// prescaler that emits count ticks while running.
module sw_ctrl
   import sw_ctrl_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int TICK_HZ   = 1,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_ss,
   input  logic       btn_lap,
   input  logic       btn_clr,
   output logic       run,
   output logic       tick,
   output logic       clr,
   output logic       lap_capture,
   output logic       hold,
   output logic [1:0] state
);

   localparam int            DIV     = CLK_HZ / TICK_HZ;
   localparam int            PW      = $clog2(DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

   logic w_ss_press, w_lap_press, w_clr_press;
   logic w_ss_ev, w_lap_ev, w_clr_ev;
   logic w_pre_wrap, w_run_next, w_cnt_en;
   logic w_clr_next, w_cap_next, w_pend_next;
   state_t w_next;

   state_t        r_state;
   logic          r_run, r_tick, r_clr, r_cap, r_hold, r_lap_pend;
   logic [PW-1:0] r_presc;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
      .clk(clk), .rst(rst), .i_btn(btn_ss), .o_press(w_ss_press)
   );
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
      .clk(clk), .rst(rst), .i_btn(btn_lap), .o_press(w_lap_press)
   );
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
      .clk(clk), .rst(rst), .i_btn(btn_clr), .o_press(w_clr_press)
   );

   // Priority clr > ss > lap; a lap deferred by one cycle competes as a lap.
   assign w_clr_ev   = w_clr_press;
   assign w_ss_ev    = w_ss_press & ~w_clr_press;
   assign w_lap_ev   = (w_lap_press | r_lap_pend) & ~w_ss_press & ~w_clr_press;
   assign w_pre_wrap = (r_presc == PRE_MAX);

   always_comb begin
      w_next      = r_state;
      w_clr_next  = 1'b0;
      w_cap_next  = 1'b0;
      w_pend_next = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_clr_ev)     w_clr_next = 1'b1;
            else if (w_ss_ev) w_next     = ST_RUN;
         end
         ST_RUN: begin
            if (w_ss_ev) begin
               w_next = ST_PAUSE;
            end else if (w_lap_ev) begin
               // A capture landing on a tick would coincide with it; take it one cycle later.
               if (w_pre_wrap) begin
                  w_pend_next = 1'b1;
               end else begin
                  w_next     = ST_LAP;
                  w_cap_next = 1'b1;
               end
            end
         end
         ST_LAP: begin
            if (w_ss_ev)       w_next = ST_PAUSE;
            else if (w_lap_ev) w_next = ST_RUN;
         end
         ST_PAUSE: begin
            if (w_clr_ev) begin
               w_next     = ST_IDLE;
               w_clr_next = 1'b1;
            end else if (w_ss_ev) begin
               w_next = ST_RUN;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Counting only while running before and after the edge freezes the
   // prescaler on pause and delays the first count on entry by one cycle.
   assign w_run_next = is_running(w_next);
   assign w_cnt_en   = r_run & w_run_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_run      <= 1'b0;
         r_tick     <= 1'b0;
         r_clr      <= 1'b0;
         r_cap      <= 1'b0;
         r_hold     <= 1'b0;
         r_lap_pend <= 1'b0;
         r_presc    <= '0;
      end else begin
         r_state    <= w_next;
         r_run      <= w_run_next;
         r_hold     <= (w_next == ST_LAP);
         r_clr      <= w_clr_next;
         r_cap      <= w_cap_next;
         r_lap_pend <= w_pend_next;
         r_tick     <= 1'b0;
         if (w_clr_next) begin
            r_presc <= '0;
         end else if (w_cnt_en) begin
            if (w_pre_wrap) begin
               r_presc <= '0;
               r_tick  <= 1'b1;
            end else begin
               r_presc <= r_presc + 1'b1;
            end
         end
      end
   end

   assign run         = r_run;
   assign tick        = r_tick;
   assign clr         = r_clr;
   assign lap_capture = r_cap;
   assign hold        = r_hold;
   assign state       = r_state;

endmodule
